// File: rtl/fir_out_buffer.sv
// fir_out_buffer: elastic output buffer for the FIR sample stream.
// Captures every FIR sample (VIN/DIN, no backpressure) into a FIFO and
// re-presents it on a VALID/READY port (VOUT/DOUT/READY). It counts one
// frame of NSAMPLES samples and raises DONE once all of them are delivered.
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   VIN, DIN      FIR sample valid / data (two's complement)
//   VOUT, DOUT    downstream valid / FIFO head data
//   READY         downstream ready
//   DONE          frame delivered (sticky until reset)
//   OVF           at least one sample lost (sticky until reset)
//   LEVEL         FIFO occupancy
// Build option: define FIR_BUF_DROP_OLD_EN to overwrite the oldest entry
// on overflow instead of dropping the incoming sample.
module fir_out_buffer #(
    parameter int WIDTH    = 11,
    parameter int DEPTH    = 8,
    parameter int NSAMPLES = 1024
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     VIN,
    input  logic [WIDTH-1:0]         DIN,
    output logic                     VOUT,
    output logic [WIDTH-1:0]         DOUT,
    input  logic                     READY,
    output logic                     DONE,
    output logic                     OVF,
    output logic [$clog2(DEPTH):0]   LEVEL
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(NSAMPLES) + 1;
    localparam logic [AW:0]   PONE = 1;
    localparam logic [CW-1:0] CONE = 1;
    localparam logic [CW-1:0] NS   = CW'(NSAMPLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [CW-1:0] in_cnt_q, in_cnt_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] target;

    logic empty;
    logic full;
    logic accept;
    logic rd;
    logic lost;
    logic wr;
    logic adv;

    assign empty = (wptr_q == rptr_q);
    // Extra pointer MSB separates full from empty.
    assign full = (wptr_q[AW] != rptr_q[AW]) &&
                  (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign accept = VIN && ((state_q == S_IDLE) || (state_q == S_RUN));
    assign rd = READY && !empty;
    // A read in the same cycle makes room, so that is not an overflow.
    assign lost = accept && full && !rd;

`ifdef FIR_BUF_DROP_OLD_EN
    logic [CW-1:0] ovw_cnt_q, ovw_cnt_d;

    // When full, the tail slot is the head slot: writing there replaces
    // the oldest sample, and the head moves on to the next oldest.
    assign wr = accept;
    assign adv = rd || lost;
    assign ovw_cnt_d = lost ? ovw_cnt_q + CONE : ovw_cnt_q;
    assign target = wr_cnt_q - ovw_cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovw_cnt_q <= '0;
        end else begin
            ovw_cnt_q <= ovw_cnt_d;
        end
    end
`else
    assign wr = accept && !lost;
    assign adv = rd;
    assign target = wr_cnt_q;
`endif

    assign wptr_d    = wr ? wptr_q + PONE : wptr_q;
    assign rptr_d    = adv ? rptr_q + PONE : rptr_q;
    assign in_cnt_d  = accept ? in_cnt_q + CONE : in_cnt_q;
    assign wr_cnt_d  = wr ? wr_cnt_q + CONE : wr_cnt_q;
    assign out_cnt_d = rd ? out_cnt_q + CONE : out_cnt_q;
    assign ovf_d     = ovf_q || lost;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_RUN: begin
                // The sample that completes the frame is still taken.
                if (accept) begin
                    if (in_cnt_q + CONE == NS) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_DRAIN: begin
                if (empty && (out_cnt_q == target)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            in_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            out_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            in_cnt_q  <= in_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            out_cnt_q <= out_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage needs no reset: DOUT is masked while the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (wr) begin
            mem[wptr_q[AW-1:0]] <= DIN;
        end
    end

    assign VOUT  = !empty;
    assign DOUT  = empty ? '0 : mem[rptr_q[AW-1:0]];
    assign DONE  = (state_q == S_DONE);
    assign OVF   = ovf_q;
    assign LEVEL = wptr_q - rptr_q;

endmodule

// File: tb/tb_fir_out_buffer.sv
// Testbench for fir_out_buffer: scenario tasks with a data scoreboard.
// Three instances share stimulus: NSAMPLES=16, 64 and 1.
module tb_fir_out_buffer;

    localparam int W = 11;

    logic         CLK = 1'b0;
    logic         RST;
    logic         VIN;
    logic         READY;
    logic [W-1:0] DIN;

    logic         m_vout, m_done, m_ovf;
    logic [W-1:0] m_dout;
    logic [3:0]   m_level;
    logic         b_vout, b_done, b_ovf;
    logic [W-1:0] b_dout;
    logic [3:0]   b_level;
    logic         o_vout, o_done, o_ovf;
    logic [W-1:0] o_dout;
    logic [3:0]   o_level;

    int errs = 0;
    int checks = 0;
    logic [W-1:0] sb [$];
    logic [W-1:0] exp;

    always #5 CLK = ~CLK;

    fir_out_buffer #(.WIDTH(W), .DEPTH(8), .NSAMPLES(16)) u_main (
        .CLK(CLK), .RST(RST), .VIN(VIN), .DIN(DIN),
        .VOUT(m_vout), .DOUT(m_dout), .READY(READY),
        .DONE(m_done), .OVF(m_ovf), .LEVEL(m_level)
    );

    fir_out_buffer #(.WIDTH(W), .DEPTH(8), .NSAMPLES(64)) u_big (
        .CLK(CLK), .RST(RST), .VIN(VIN), .DIN(DIN),
        .VOUT(b_vout), .DOUT(b_dout), .READY(READY),
        .DONE(b_done), .OVF(b_ovf), .LEVEL(b_level)
    );

    fir_out_buffer #(.WIDTH(W), .DEPTH(8), .NSAMPLES(1)) u_one (
        .CLK(CLK), .RST(RST), .VIN(VIN), .DIN(DIN),
        .VOUT(o_vout), .DOUT(o_dout), .READY(READY),
        .DONE(o_done), .OVF(o_ovf), .LEVEL(o_level)
    );

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    function automatic logic [W-1:0] sb_pop();
        if (sb.size() == 0) return 'x;
        return sb.pop_front();
    endfunction

    task automatic do_reset();
        RST = 1'b1;
        VIN = 1'b0;
        READY = 1'b0;
        DIN = '0;
        repeat (3) cyc();
        RST = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (m_vout !== 1'b0 || m_done !== 1'b0 || m_ovf !== 1'b0 ||
                m_level !== 4'd0 || m_dout !== '0) begin
                errs++;
                $display("FAIL reset_idle c%0d: vout=%b done=%b ovf=%b lvl=%0d dout=%0d want all 0",
                         i, m_vout, m_done, m_ovf, m_level, m_dout);
            end
            cyc();
        end
    endtask

    task automatic test_stream();
        do_reset();
        READY = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin
                checks++;
                if (m_vout !== 1'b1) begin
                    errs++;
                    $display("FAIL stream_latency s%0d: vout=%b want 1", i, m_vout);
                end
            end
            if (m_vout && READY) begin
                exp = sb_pop();
                checks++;
                if (m_dout !== exp) begin
                    errs++;
                    $display("FAIL stream_data: dout=%0d want %0d", m_dout, exp);
                end
            end
            checks++;
            if (m_level > 4'd1) begin
                errs++;
                $display("FAIL stream_level: level=%0d want <=1", m_level);
            end
            VIN = 1'b1;
            DIN = W'(i);
            sb.push_back(DIN);
            cyc();
        end
        // Frame is full: this extra sample must be ignored.
        VIN = 1'b1;
        DIN = W'(99);
        if (m_vout) begin
            exp = sb_pop();
            checks++;
            if (m_dout !== exp) begin
                errs++;
                $display("FAIL stream_last: dout=%0d want %0d", m_dout, exp);
            end
        end
        cyc();
        VIN = 1'b0;
        checks++;
        if (m_vout !== 1'b0 || m_done !== 1'b0) begin
            errs++;
            $display("FAIL stream_drain: vout=%b done=%b want 0/0", m_vout, m_done);
        end
        cyc();
        checks++;
        if (m_done !== 1'b1 || sb.size() != 0) begin
            errs++;
            $display("FAIL stream_done: done=%b left=%0d want 1/0", m_done, sb.size());
        end
        VIN = 1'b1;
        repeat (3) cyc();
        VIN = 1'b0;
        checks++;
        if (m_done !== 1'b1 || m_vout !== 1'b0 || m_ovf !== 1'b0) begin
            errs++;
            $display("FAIL done_sticky: done=%b vout=%b ovf=%b want 1/0/0",
                     m_done, m_vout, m_ovf);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] vals [8];
        vals = '{11'h400, 11'h3FF, 11'd5, 11'h7FB, 11'd0, 11'h7FF, 11'd100, 11'h6D4};
        do_reset();
        READY = 1'b0;
        for (int i = 0; i < 8; i++) begin
            VIN = 1'b1;
            DIN = vals[i];
            sb.push_back(DIN);
            cyc();
        end
        VIN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_level !== 4'd8 || m_vout !== 1'b1 || m_dout !== 11'h400) begin
                errs++;
                $display("FAIL bp_hold c%0d: lvl=%0d vout=%b dout=%0d want 8/1/%0d",
                         i, m_level, m_vout, $signed(m_dout), -1024);
            end
            cyc();
        end
        READY = 1'b1;
        for (int n = 0; n < 20 && sb.size() > 0; n++) begin
            if (m_vout) begin
                exp = sb_pop();
                checks++;
                if (m_dout !== exp) begin
                    errs++;
                    $display("FAIL bp_data: dout=%0d want %0d",
                             $signed(m_dout), $signed(exp));
                end
            end
            cyc();
        end
        checks++;
        if (sb.size() != 0 || m_level !== 4'd0 || m_ovf !== 1'b0) begin
            errs++;
            $display("FAIL bp_end: left=%0d lvl=%0d ovf=%b want 0/0/0",
                     sb.size(), m_level, m_ovf);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        READY = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            checks++;
            if (m_ovf !== (i > 9)) begin
                errs++;
                $display("FAIL ovf_flag w%0d: ovf=%b want %b", i, m_ovf, (i > 9));
            end
            VIN = 1'b1;
            DIN = W'(i);
            if (sb.size() < 8) begin
                sb.push_back(DIN);
            end else begin
`ifdef FIR_BUF_DROP_OLD_EN
                void'(sb.pop_front());
                sb.push_back(DIN);
`endif
            end
            cyc();
        end
        VIN = 1'b0;
        checks++;
        if (m_ovf !== 1'b1 || m_level !== 4'd8) begin
            errs++;
            $display("FAIL ovf_full: ovf=%b lvl=%0d want 1/8", m_ovf, m_level);
        end
        READY = 1'b1;
        for (int n = 0; n < 20 && sb.size() > 0; n++) begin
            if (m_vout) begin
                exp = sb_pop();
                checks++;
                if (m_dout !== exp) begin
                    errs++;
                    $display("FAIL ovf_data: dout=%0d want %0d", m_dout, exp);
                end
            end
            cyc();
        end
        checks++;
        if (sb.size() != 0 || m_vout !== 1'b0 || m_ovf !== 1'b1) begin
            errs++;
            $display("FAIL ovf_end: left=%0d vout=%b ovf=%b want 0/0/1",
                     sb.size(), m_vout, m_ovf);
        end
    endtask

    task automatic test_full_rw();
        do_reset();
        READY = 1'b0;
        for (int i = 0; i < 8; i++) begin
            VIN = 1'b1;
            DIN = W'(100 + i);
            sb.push_back(DIN);
            cyc();
        end
        for (int i = 0; i < 20; i++) begin
            READY = 1'b1;
            checks++;
            if (b_level !== 4'd8 || b_ovf !== 1'b0) begin
                errs++;
                $display("FAIL full_rw_level c%0d: lvl=%0d ovf=%b want 8/0",
                         i, b_level, b_ovf);
            end
            if (b_vout && READY) begin
                exp = sb_pop();
                checks++;
                if (b_dout !== exp) begin
                    errs++;
                    $display("FAIL full_rw_data: dout=%0d want %0d", b_dout, exp);
                end
            end
            VIN = 1'b1;
            DIN = W'(200 + i);
            sb.push_back(DIN);
            cyc();
        end
        VIN = 1'b0;
        for (int n = 0; n < 20 && sb.size() > 0; n++) begin
            if (b_vout) begin
                exp = sb_pop();
                checks++;
                if (b_dout !== exp) begin
                    errs++;
                    $display("FAIL full_rw_drain: dout=%0d want %0d", b_dout, exp);
                end
            end
            cyc();
        end
        checks++;
        if (sb.size() != 0 || b_level !== 4'd0 || b_ovf !== 1'b0) begin
            errs++;
            $display("FAIL full_rw_end: left=%0d lvl=%0d ovf=%b want 0/0/0",
                     sb.size(), b_level, b_ovf);
        end
    endtask

    task automatic test_midframe_reset();
        do_reset();
        READY = 1'b0;
        for (int i = 0; i < 7; i++) begin
            VIN = 1'b1;
            DIN = W'(50 + i);
            cyc();
        end
        VIN = 1'b0;
        RST = 1'b1;
        #1;
        checks++;
        if (m_vout !== 1'b0 || m_dout !== '0 || m_done !== 1'b0 ||
            m_ovf !== 1'b0 || m_level !== 4'd0) begin
            errs++;
            $display("FAIL async_reset: vout=%b dout=%0d done=%b ovf=%b lvl=%0d want 0",
                     m_vout, m_dout, m_done, m_ovf, m_level);
        end
        cyc();
        cyc();
        RST = 1'b0;
        sb.delete();
        for (int i = 0; i < 16; i++) begin
            READY = (i % 3) != 0;
            if (m_vout && READY) begin
                exp = sb_pop();
                checks++;
                if (m_dout !== exp) begin
                    errs++;
                    $display("FAIL mid_data: dout=%0d want %0d", m_dout, exp);
                end
            end
            VIN = 1'b1;
            DIN = W'(300 + i);
            sb.push_back(DIN);
            cyc();
        end
        VIN = 1'b0;
        READY = 1'b1;
        for (int n = 0; n < 30 && !m_done; n++) begin
            if (m_vout) begin
                exp = sb_pop();
                checks++;
                if (m_dout !== exp) begin
                    errs++;
                    $display("FAIL mid_drain: dout=%0d want %0d", m_dout, exp);
                end
            end
            cyc();
        end
        checks++;
        if (m_done !== 1'b1 || m_ovf !== 1'b0 || sb.size() != 0) begin
            errs++;
            $display("FAIL mid_done: done=%b ovf=%b left=%0d want 1/0/0",
                     m_done, m_ovf, sb.size());
        end
    endtask

    task automatic test_nsamples1();
        do_reset();
        READY = 1'b1;
        VIN = 1'b1;
        DIN = W'(7);
        cyc();
        checks++;
        if (o_vout !== 1'b1 || o_dout !== W'(7)) begin
            errs++;
            $display("FAIL ns1_first: vout=%b dout=%0d want 1/7", o_vout, o_dout);
        end
        DIN = W'(9);
        cyc();
        VIN = 1'b0;
        checks++;
        if (o_vout !== 1'b0 || o_done !== 1'b0 || o_level !== 4'd0) begin
            errs++;
            $display("FAIL ns1_drain: vout=%b done=%b lvl=%0d want 0/0/0",
                     o_vout, o_done, o_level);
        end
        cyc();
        checks++;
        if (o_done !== 1'b1) begin
            errs++;
            $display("FAIL ns1_done: done=%b want 1", o_done);
        end
    endtask

    initial begin
        RST = 1'b1;
        VIN = 1'b0;
        READY = 1'b0;
        DIN = '0;
        @(negedge CLK);
        test_reset();
        test_stream();
        test_backpressure();
        test_overflow();
        test_full_rw();
        test_midframe_reset();
        test_nsamples1();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
